ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
// - Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
// - Pairs with the existing PS/2 receive path on the shared open-drain PS2_CLK/PS2_DATA pins.
// - Performs the request-to-send sequence, shifts the frame on device-generated clock edges, checks the device ACK.
// - Top level drives pins as: PS2_x = ps2_x_oe ? 1'b0 : 1'bz.
// PARAMETERS
// - INHIBIT_CYC  12000      clk cycles PS2_CLK is held low for RTS (120 us at 100 MHz)
// - TIMEOUT_CYC  2000000    max clk cycles between PS2 clock falling edges (20 ms)
// - SYNC_STAGES  2          flip-flop stages synchronising each PS/2 input (>=2)
// PORTS
// - clk          in   1  system clock, 100 MHz
// - rst          in   1  synchronous reset, active-high
// - tx_data      in   8  command byte to send
// - tx_valid     in   1  request; accepted on the cycle where tx_valid && tx_ready
// - tx_ready     out  1  high only in IDLE
// - busy         out  1  high from accept until DONE/ERR; receive path ignores bus while high
// - tx_done      out  1  one-cycle pulse: frame sent and ACK seen
// - tx_err       out  1  one-cycle pulse: ACK missing or timeout
// - ps2_clk_in   in   1  raw PS2_CLK pin level (asynchronous)
// - ps2_data_in  in   1  raw PS2_DATA pin level (asynchronous)
// - ps2_clk_oe   out  1  1 = pull PS2_CLK low
// - ps2_data_oe  out  1  1 = pull PS2_DATA low
// BEHAVIOUR
// - Reset: tx_ready=1; busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe = 0; state IDLE.
// - Reset mid-frame: both lines are released on the next clock edge; the partial frame is abandoned with no pulse.
// - Inputs pass through SYNC_STAGES synchronisers. A fall is a synced 1->0 transition of PS2_CLK, one cycle wide.
// - Accept: latch tx_data; parity = ~^tx_data (odd parity); bit counter = 0.
// - tx_valid while busy is ignored; no queueing.
// - IDLE -> INHIBIT on accept.
// - INHIBIT: clk_oe=1 for INHIBIT_CYC cycles.
//   - On the last inhibit cycle, data_oe=1 (start bit 0) while clk_oe is still 1.
//   - Then go to SHIFT.
// - SHIFT: clk_oe=0, start bit held. On each fall, bit counter k increments and drives:
//   - k=1..8 -> data bit k-1, LSB first; data_oe = ~bit.
//   - k=9 -> parity bit.
//   - k=10 -> stop bit; data_oe=0 (line released). Then go to ACK.
// - ACK: on the next fall, sample synced data.
//   - 0 -> WAIT_IDLE.
//   - 1 -> ERR.
// - WAIT_IDLE: wait until synced clk=1 and data=1, then DONE.
// - DONE / ERR: one cycle; pulse tx_done or tx_err; release both lines; busy=0; next state IDLE.
// - tx_ready rises the cycle after DONE/ERR.
// - Fall during INHIBIT (device activity) is ignored; the inhibit sequence overrides it.
// - tx_done and tx_err are never asserted in the same cycle.
// - Latency: accept -> first clk release = INHIBIT_CYC+1 cycles; the rest is paced by the device (10-16.7 kHz).
// CONFIGURATION
// - PS2_TX_TIMEOUT_EN defined:
//   - A watchdog counts cycles since the last fall, or since SHIFT entry, in SHIFT/ACK/WAIT_IDLE.
//   - It resets on each fall.
//   - Reaching TIMEOUT_CYC -> ERR: both lines released, tx_err pulsed.
// - PS2_TX_TIMEOUT_EN undefined:
//   - No watchdog; the FSM waits for the device indefinitely.
//   - Only rst recovers a missing device.
// TESTING
// - Send 0xED with a device model (12.5 kHz):
//   - line bits after start are 1,0,1,1,0,1,1,1; parity 1; stop 1.
//   - model ACKs -> exactly one tx_done, no tx_err; tx_ready back high.
// - Send 0x07 -> parity bit 0.
// - Send 0xFF -> parity bit 1. Model checks odd parity over 9 bits for both.
// - Inhibit timing: clk_oe high for exactly INHIBIT_CYC cycles.
//   - data_oe rises on the last of those cycles, before clk_oe falls.
// - Model omits ACK (data high at 11th fall) -> tx_err pulse one cycle; both oe=0; tx_done never asserted.
// - tx_valid pulsed with 0x55 mid-frame of 0xF4 -> ignored; only 0xF4 appears on bus.
// - rst asserted at bit 4:
//   - next cycle both oe=0, tx_ready=1, no done/err.
//   - a following 0xFF frame completes normally.
// - PS2_TX_TIMEOUT_EN defined, model stops clocking after 3 bits:
//   - tx_err exactly TIMEOUT_CYC cycles after the last fall.
//   - Undefined: busy stays high.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a PS/2 host transmitter and its client logic.
// tx_valid/tx_ready: a byte moves on the cycle where both are high; tx_data must be stable while tx_valid is high.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, device-clocked frame shift, ACK check.
// Optional watchdog on device clocking is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 12000,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_SHIFT     = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s, clk_prev, fall;
  logic [9:0]             frame;
  logic [3:0]             bit_cnt;
  logic [INH_W-1:0]       inh_cnt;
  logic                   inh_last;
  logic                   data_drv;
  logic                   accept;
  logic                   wd_expire;

  // Idle bus level is high, so the synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_s;
  assign accept   = tx.tx_valid && (state == S_IDLE);
  assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYC - 1));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);
  // The count includes the fall cycle itself, so expiry lands TIMEOUT_CYC cycles after it.
  assign wd_expire = wd_active && !fall && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst)                   wd_cnt <= '0;
    else if (!wd_active || fall) wd_cnt <= WD_W'(1);
    else                       wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // frame = {stop, odd parity, data}; data_drv holds the open-drain pull for the current bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame    <= '0;
      bit_cnt  <= '0;
      inh_cnt  <= '0;
      data_drv <= 1'b0;
    end else if (accept) begin
      frame    <= {1'b1, ~^tx.tx_data, tx.tx_data};
      bit_cnt  <= '0;
      inh_cnt  <= '0;
      data_drv <= 1'b1;
    end else begin
      if (state == S_INHIBIT) inh_cnt <= inh_cnt + 1'b1;
      if ((state == S_SHIFT) && fall) begin
        data_drv <= ~frame[bit_cnt];
        bit_cnt  <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    tx.tx_ready = 1'b0;
    tx.busy     = 1'b0;
    tx.tx_done  = 1'b0;
    tx.tx_err   = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx.tx_ready = 1'b1;
        if (tx.tx_valid) state_nx = S_INHIBIT;
      end
      S_INHIBIT: begin
        tx.busy     = 1'b1;
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = inh_last;
        if (inh_last) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        tx.busy     = 1'b1;
        ps2_data_oe = data_drv;
        if (fall && (bit_cnt == 4'd9)) state_nx = S_ACK;
      end
      S_ACK: begin
        tx.busy = 1'b1;
        if (fall) state_nx = data_s ? S_ERR : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        tx.busy = 1'b1;
        if (clk_s && data_s) state_nx = S_DONE;
      end
      S_DONE: begin
        tx.tx_done = 1'b1;
        state_nx   = S_IDLE;
      end
      S_ERR: begin
        tx.tx_err = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (wd_expire) state_nx = S_ERR;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the shared lines, a byte queue holds expected frames.
module tb_ps2_host_tx;
  localparam int INHIBIT_CYC = 20;
  localparam int TIMEOUT_CYC = 300;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;
  logic [2:0] state_dbg;

  ps2_host_tx_if tx_if();

  // Open-drain wired-AND with pull-ups
  assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYC(INHIBIT_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (tx_if),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0;
  int run = 0, data_pos = 0, last_run = 0, last_data_pos = 0;
  int fall_drive_cyc = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Pulse counters and inhibit-window measurement
  always @(negedge clk) begin
    if (tx_if.tx_done) done_cnt++;
    if (tx_if.tx_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (tx_if.tx_done && tx_if.tx_err) both_cnt++;
    if (ps2_clk_oe) begin
      run++;
      if (ps2_data_oe && data_pos == 0) data_pos = run;
    end else if (run != 0) begin
      last_run      = run;
      last_data_pos = data_pos;
      run           = 0;
      data_pos      = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host transmission against the device model. n_falls < 11 stalls the device;
  // poke_k pulses tx_valid after that fall; rst_k asserts rst after that fall.
  task automatic send_frame(input logic [7:0] b, input bit ack, input int n_falls,
                            input int poke_k, input int rst_k);
    logic [10:0] bits;
    logic [7:0]  exp_b;
    int          ones, d0, e0;
    bit          got;
    bits = '0;
    exp_q.push_back(b);
    d0 = done_cnt;
    e0 = err_cnt;
    check("ready_before", tx_if.tx_ready, 1);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    step();
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'($urandom_range(0, 255));
    check("busy_after_accept", tx_if.busy, 1);
    got = 0;
    for (int i = 0; i < INHIBIT_CYC + 20 && !got; i++) begin
      if (ps2_data_oe && !ps2_clk_oe) got = 1;
      else step();
    end
    check("rts_seen", got, 1);
    check("inhibit_len", last_run, INHIBIT_CYC);
    check("start_on_last_inhibit", last_data_pos, INHIBIT_CYC);
    repeat (HALF) step();
    bits[0] = ps2_data_line;
    for (int k = 1; k <= n_falls; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (4) step();
      end
      dev_clk_low    = 1'b1;
      fall_drive_cyc = cyc;
      if (k == poke_k) begin
        step();
        tx_if.tx_data  = 8'h55;
        tx_if.tx_valid = 1'b1;
        step();
        tx_if.tx_valid = 1'b0;
        repeat (HALF - 2) step();
      end else begin
        repeat (HALF) step();
      end
      if (k <= 10) bits[k] = ps2_data_line;
      dev_clk_low = 1'b0;
      repeat (HALF) step();
      dev_data_low = 1'b0;
      if (k == rst_k) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_clk_released", ps2_clk_oe, 0);
        check("rst_data_released", ps2_data_oe, 0);
        check("rst_ready", tx_if.tx_ready, 1);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_err", err_cnt - e0, 0);
        void'(exp_q.pop_back());
        return;
      end
    end
    if (n_falls < 11) begin
      void'(exp_q.pop_back());
      return;
    end
    exp_b = exp_q.pop_front();
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(exp_b[i]);
    check("start_bit", bits[0], 0);
    check("data_byte", bits[8:1], exp_b);
    check("parity_bit", bits[9], (ones % 2 == 0) ? 1 : 0);
    ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(bits[i]);
    check("odd_parity9", ones % 2, 1);
    check("stop_bit", bits[10], 1);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done_cnt != d0 || err_cnt != e0) got = 1;
      else step();
    end
    check("end_event", got, 1);
    repeat (5) step();
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("err_pulses", err_cnt - e0, ack ? 0 : 1);
    check("done_err_overlap", both_cnt, 0);
    check("end_clk_released", ps2_clk_oe, 0);
    check("end_data_released", ps2_data_oe, 0);
    check("ready_after", tx_if.tx_ready, 1);
    check("busy_after", tx_if.busy, 0);
  endtask

  initial begin
    int  e0;
    bit  got;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) step();
    check("reset_ready", tx_if.tx_ready, 1);
    check("reset_busy", tx_if.busy, 0);
    check("reset_done", tx_if.tx_done, 0);
    check("reset_err", tx_if.tx_err, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    rst = 1'b0;
    step();

    send_frame(8'hED, 1'b1, 11, 0, 0);
    send_frame(8'h07, 1'b1, 11, 0, 0);
    send_frame(8'hFF, 1'b1, 11, 0, 0);
    send_frame(8'hA5, 1'b0, 11, 0, 0);
    send_frame(8'hF4, 1'b1, 11, 5, 0);
    send_frame(8'h3C, 1'b1, 11, 0, 4);
    send_frame(8'hFF, 1'b1, 11, 0, 0);
    for (int r = 0; r < 4; r++)
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 11, 0, 0);

    // Device stops clocking after 3 bits
    e0 = err_cnt;
    send_frame(8'h12, 1'b1, 3, 0, 0);
`ifdef PS2_TX_TIMEOUT_EN
    got = 0;
    for (int i = 0; i < TIMEOUT_CYC + 100 && !got; i++) begin
      if (err_cnt != e0) got = 1;
      else step();
    end
    check("timeout_err_seen", got, 1);
    check("timeout_latency", err_cyc - fall_drive_cyc, TIMEOUT_CYC + SYNC_STAGES);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_clk_released", ps2_clk_oe, 0);
    check("timeout_data_released", ps2_data_oe, 0);
    step();
    check("timeout_ready", tx_if.tx_ready, 1);
`else
    repeat (TIMEOUT_CYC + 100) step();
    check("stall_busy", tx_if.busy, 1);
    check("stall_no_err", err_cnt - e0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stall_rst_ready", tx_if.tx_ready, 1);
`endif
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
